hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, PC-write flush and operand
// forwarding control with saturating stall/flush counters.
module hazard_unit #(
  parameter int AW     = 4,
  parameter int NRP    = 2,
  parameter int PC_IDX = 15,
  parameter int CW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic [AW-1:0]     WA3D,
  input  logic [NRP*AW-1:0] RAD,
  input  logic [NRP-1:0]    REnD,
  input  logic              BranchTakenE,
  input  logic              CntClr,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [2*NRP-1:0]  ForwardE,
  output logic [CW-1:0]     StallCnt,
  output logic [CW-1:0]     FlushCnt
);

  localparam logic [AW-1:0] PC = AW'(PC_IDX);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memtoreg;
    logic          pcwr;
    logic [AW-1:0] wa;
  } ent_t;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          pcwr;
    logic [AW-1:0] wa;
  } wb_t;

  ent_t              d_ent;
  ent_t              e_q;
  ent_t              m_q;
  wb_t               w_q;
  logic [NRP*AW-1:0] e_ra;
  logic [NRP-1:0]    e_ren;

  logic d_act, e_act, m_act, w_act;
  logic ldrstall, pc_pend, pc_w;

  always_comb begin
    d_ent.valid    = ValidD;
    d_ent.regwrite = RegWriteD;
    d_ent.memtoreg = MemtoRegD;
    d_ent.pcwr     = RegWriteD && (WA3D == PC);
    d_ent.wa       = WA3D;
  end

  assign d_act = ValidD && RegWriteD;
  assign e_act = e_q.valid && e_q.regwrite;
  assign m_act = m_q.valid && m_q.regwrite;
  assign w_act = w_q.valid && w_q.regwrite;

  always_comb begin
    ldrstall = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      if (REnD[p] && (RAD[p*AW +: AW] == e_q.wa))
        ldrstall = 1'b1;
    end
    ldrstall = ldrstall && ValidD && e_act && e_q.memtoreg;
  end

  assign pc_pend = (d_act && d_ent.pcwr)
                 || (e_act && e_q.pcwr)
                 || (m_act && m_q.pcwr);
  assign pc_w    = w_act && w_q.pcwr;

  assign StallD = ldrstall;
  assign StallF = ldrstall || pc_pend;
  assign FlushD = pc_pend || pc_w || BranchTakenE;
  assign FlushE = ldrstall || BranchTakenE;

  // M wins over W; loads in M have no result yet, PC never forwards
  always_comb begin
    ForwardE = '0;
    for (int p = 0; p < NRP; p++) begin
      if (e_q.valid && e_ren[p]) begin
        if (m_act && !m_q.memtoreg
            && (m_q.wa == e_ra[p*AW +: AW])
            && (m_q.wa != PC))
          ForwardE[2*p +: 2] = 2'b10;
        else if (w_act
            && (w_q.wa == e_ra[p*AW +: AW])
            && (w_q.wa != PC))
          ForwardE[2*p +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      e_ra     <= '0;
      e_ren    <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (FlushE) begin
        e_q <= '0;
      end else begin
        e_q   <= d_ent;
        e_ra  <= RAD;
        e_ren <= REnD;
      end
      m_q          <= e_q;
      w_q.valid    <= m_q.valid;
      w_q.regwrite <= m_q.regwrite;
      w_q.pcwr     <= m_q.pcwr;
      w_q.wa       <= m_q.wa;
      if (CntClr) begin
        StallCnt <= '0;
        FlushCnt <= '0;
      end else begin
        if (StallD && (StallCnt != '1))
          StallCnt <= StallCnt + CW'(1);
        if (FlushE && (FlushCnt != '1))
          FlushCnt <= FlushCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: random + directed stimulus, queue scoreboard
// against an instruction-level pipeline model.
module tb_hazard_unit;

  localparam int AW  = 4;
  localparam int NRP = 2;
  localparam int CW  = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ValidD = 1'b0;
  logic RegWriteD = 1'b0;
  logic MemtoRegD = 1'b0;
  logic BranchTakenE = 1'b0;
  logic CntClr = 1'b0;
  logic [AW-1:0] WA3D = '0;
  logic [NRP*AW-1:0] RAD = '0;
  logic [NRP-1:0] REnD = '0;
  logic StallF, StallD, FlushD, FlushE;
  logic [2*NRP-1:0] ForwardE;
  logic [CW-1:0] StallCnt, FlushCnt;

  hazard_unit #(
    .AW(AW), .NRP(NRP), .PC_IDX(15), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ValidD(ValidD),
    .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD),
    .WA3D(WA3D),
    .RAD(RAD),
    .REnD(REnD),
    .BranchTakenE(BranchTakenE),
    .CntClr(CntClr),
    .StallF(StallF),
    .StallD(StallD),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .ForwardE(ForwardE),
    .StallCnt(StallCnt),
    .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit v, rw, ld;
    bit [3:0] wa, ra0, ra1;
    bit en0, en1;
  } ins_t;

  typedef struct packed {
    bit sf, sd, fd, fe;
    bit [3:0] fw;
    bit [1:0] sc, fc;
  } exp_t;

  ins_t pipe [3];
  int sc, fc;
  exp_t q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic ins_t d_ins();
    ins_t i;
    i.v = ValidD; i.rw = RegWriteD; i.ld = MemtoRegD;
    i.wa = WA3D; i.ra0 = RAD[3:0]; i.ra1 = RAD[7:4];
    i.en0 = REnD[0]; i.en1 = REnD[1];
    return i;
  endfunction

  function automatic bit act(input ins_t i);
    return i.v && i.rw;
  endfunction

  function automatic bit pcw(input ins_t i);
    return act(i) && i.wa == 4'd15;
  endfunction

  function automatic bit load_use();
    ins_t e = pipe[0];
    bit hit0 = REnD[0] && RAD[3:0] == e.wa;
    bit hit1 = REnD[1] && RAD[7:4] == e.wa;
    return act(e) && e.ld && ValidD && (hit0 || hit1);
  endfunction

  function automatic bit [1:0] fwd(input int p);
    ins_t e = pipe[0];
    ins_t m = pipe[1];
    ins_t w = pipe[2];
    bit [3:0] ra = (p == 1) ? e.ra1 : e.ra0;
    bit en = (p == 1) ? e.en1 : e.en0;
    if (!e.v || !en) return 2'd0;
    if (act(m) && !m.ld && m.wa == ra && m.wa != 4'd15) return 2'd2;
    if (act(w) && w.wa == ra && w.wa != 4'd15) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t expect_now();
    exp_t r;
    bit lu = load_use();
    bit pend = pcw(d_ins()) || pcw(pipe[0]) || pcw(pipe[1]);
    r.sd = lu;
    r.sf = lu || pend;
    r.fd = pend || pcw(pipe[2]) || BranchTakenE;
    r.fe = lu || BranchTakenE;
    r.fw = {fwd(1), fwd(0)};
    r.sc = sc[1:0];
    r.fc = fc[1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    sc = 0;
    fc = 0;
  endtask

  task automatic model_advance();
    bit lu = load_use();
    bit fe = lu || BranchTakenE;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = fe ? '0 : d_ins();
    if (CntClr) begin
      sc = 0;
      fc = 0;
    end else begin
      if (lu && sc < CMAX) sc++;
      if (fe && fc < CMAX) fc++;
    end
  endtask

  task automatic compare(input exp_t e);
    chk("StallF", int'(StallF), int'(e.sf));
    chk("StallD", int'(StallD), int'(e.sd));
    chk("FlushD", int'(FlushD), int'(e.fd));
    chk("FlushE", int'(FlushE), int'(e.fe));
    chk("ForwardE", int'(ForwardE), int'(e.fw));
    chk("StallCnt", int'(StallCnt), int'(e.sc));
    chk("FlushCnt", int'(FlushCnt), int'(e.fc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_advance();
    #1;
  endtask

  task automatic apply();
    q.push_back(expect_now());
  endtask

  task automatic issue(input bit v, input bit rw, input bit ld,
                       input bit [3:0] wa, input bit [3:0] ra0,
                       input bit [3:0] ra1, input bit [1:0] en,
                       input bit bt, input bit clr);
    tick();
    ValidD = v; RegWriteD = rw; MemtoRegD = ld; WA3D = wa;
    RAD = {ra1, ra0}; REnD = en; BranchTakenE = bt; CntClr = clr;
    apply();
  endtask

  function automatic bit [3:0] pick();
    int r = $urandom_range(0, 7);
    return (r == 7) ? 4'd15 : 4'(r % 4 + 1);
  endfunction

  task automatic rand_issue();
    issue($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, pick(), pick(), pick(),
          2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
          $urandom_range(0, 15) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : stim
    model_reset();
    tick(); apply();
    tick(); apply();
    @(negedge clk);
    #2 reset = 1'b1;

    // dependent ALU chain: forward from M then from W
    issue(1, 1, 0, 4'd1, 4'd0, 4'd0, 2'b00, 0, 0);
    issue(1, 1, 0, 4'd2, 4'd1, 4'd3, 2'b01, 0, 0);
    issue(1, 1, 0, 4'd3, 4'd1, 4'd0, 2'b01, 0, 0);
    idle(3);
    // load-use on port1, consumer held in D for one extra cycle
    issue(1, 1, 1, 4'd4, 4'd0, 4'd0, 2'b00, 0, 0);
    issue(1, 1, 0, 4'd6, 4'd0, 4'd4, 2'b10, 0, 0);
    issue(1, 1, 0, 4'd6, 4'd0, 4'd4, 2'b10, 0, 0);
    idle(3);
    // branch during load-use
    issue(1, 1, 1, 4'd5, 4'd0, 4'd0, 2'b00, 0, 0);
    issue(1, 1, 0, 4'd7, 4'd5, 4'd0, 2'b01, 1, 0);
    idle(3);
    // PC write followed by readers of r15
    issue(1, 1, 0, 4'd15, 4'd0, 4'd0, 2'b00, 0, 0);
    repeat (5) issue(1, 0, 0, 4'd0, 4'd15, 4'd15, 2'b11, 0, 0);
    // flush counter saturation, then clear under a branch
    repeat (5) issue(0, 0, 0, 4'd0, 4'd0, 4'd0, 2'b00, 1, 0);
    issue(0, 0, 0, 4'd0, 4'd0, 4'd0, 2'b00, 1, 1);
    idle(2);

    repeat (3000) rand_issue();

    // reset pulled low mid load-use stall
    issue(1, 1, 1, 4'd4, 4'd0, 4'd0, 2'b00, 0, 0);
    issue(1, 0, 0, 4'd0, 4'd0, 4'd4, 2'b10, 0, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    model_reset();
    compare(expect_now());
    tick(); apply();
    @(negedge clk);
    #2 reset = 1'b1;
    issue(1, 1, 0, 4'd5, 4'd6, 4'd7, 2'b11, 0, 0);
    idle(3);

    repeat (500) rand_issue();

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
